sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
// Single-clock, parametrised FIFO for the async_fifo test environment.
// Generalises the 9-bit async FIFO: configurable width/depth, programmable
// half-full/half-empty thresholds, fill count, sticky overflow/underflow and
// synchronous flush. Used as reference model and as on-chip elastic buffer.
// PARAMETERS
// DATA_WIDTH  9         width of wData/rData
// DEPTH       16        entries; power of 2, >= 4
// HF_THRESH   DEPTH/2   wHalf_full asserts when count >= HF_THRESH
// HE_THRESH   DEPTH/2   rHalf_empty asserts when count <= HE_THRESH
// PORTS
// wclk         in   1                   clock, all logic on posedge
// wrst         in   1                   async reset, active-high
// winc         in   1                   write request
// wData        in   DATA_WIDTH          write data
// rinc         in   1                   read request
// rData        out  DATA_WIDTH          read data, registered
// rEmpty       out  1                   count == 0
// rHalf_empty  out  1                   count <= HE_THRESH
// wFull        out  1                   count == DEPTH
// wHalf_full   out  1                   count >= HF_THRESH
// count        out  $clog2(DEPTH)+1     current occupancy, 0..DEPTH
// flush        in   1                   sync clear of pointers/count
// clr_err      in   1                   sync clear of sticky error flags
// wOverflow    out  1                   sticky: winc while wFull
// rUnderflow   out  1                   sticky: rinc while rEmpty
// BEHAVIOUR
// - One clock (wclk); reset is asynchronous and active-high (wrst).
// - Reset: pointers=0, count=0, rData=0, rEmpty=1, rHalf_empty=1, wFull=0,
//   wHalf_full=0 (1 only if HF_THRESH==0), wOverflow=0, rUnderflow=0.
//   Memory contents not reset. Reset mid-operation discards all data.
// - Pointers: $clog2(DEPTH)+1 bits, MSB is wrap bit; wrap at DEPTH silently.
// - Write accepted = winc & ~wFull; mem[wptr]<=wData, wptr++.
// - Read accepted = rinc & ~rEmpty; rData<=mem[rptr], rptr++; rData valid
//   the cycle after acceptance, holds value when no read accepted.
// - Flags/count are registered, evaluated on pre-edge count: write to empty
//   FIFO -> rEmpty deasserts 1 cycle later; earliest read is then.
// - Simultaneous accepted read+write: count unchanged; legal at any level.
// - winc&rinc while full: read accepted, write rejected, wOverflow set.
// - winc&rinc while empty: write accepted, read rejected, rUnderflow set.
// - Rejected access leaves memory, pointers, rData unchanged.
// - flush: next edge pointers=0, count=0, flags as reset; wins over winc/rinc
//   same cycle; rData and error flags unaffected.
// - clr_err clears sticky flags; if a new error occurs same cycle, flag sets.
// - No combinational path from inputs to outputs.
// - Elaboration error if DEPTH not power of 2 or thresholds > DEPTH.
// TESTING
// 1 Reset: assert wrst async mid-cycle -> all outputs reset values at once.
// 2 Fill: 16 writes 9'h100..9'h10F -> wHalf_full after 8th, wFull after 16th,
//   count=16; 17th write 9'h1FF -> wOverflow=1, contents unchanged.
// 3 Drain: 16 reads -> rData 9'h100..9'h10F in order, 1-cycle latency; 17th
//   read -> rUnderflow=1, rData holds 9'h10F; clr_err -> both flags 0.
// 4 Wrap: 40 interleaved writes/reads of incrementing data -> in-order, no loss.
// 5 Simultaneous winc&rinc at count=8 for 20 cycles -> count stays 8, order ok.
// 6 flush at count=5 with winc=1 -> count=0, rEmpty=1, write dropped;
//   wrst pulse at count=10 -> rEmpty=1, count=0 immediately.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param_if
// Description : Handshake/data bundle for sync_fifo_param. The master side
//               issues write/read/flush/clr_err. The slave side (the FIFO)
//               returns read data, flags, fill count and sticky errors.
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_param_if #(
   parameter int DATA_WIDTH = 9,
   parameter int DEPTH      = 16
);
   logic                     winc;
   logic [DATA_WIDTH-1:0]    wData;
   logic                     rinc;
   logic [DATA_WIDTH-1:0]    rData;
   logic                     rEmpty;
   logic                     rHalf_empty;
   logic                     wFull;
   logic                     wHalf_full;
   logic [$clog2(DEPTH):0]   count;
   logic                     flush;
   logic                     clr_err;
   logic                     wOverflow;
   logic                     rUnderflow;

   modport master (
      output winc, wData, rinc, flush, clr_err,
      input  rData, rEmpty, rHalf_empty, wFull, wHalf_full, count,
             wOverflow, rUnderflow
   );

   modport slave (
      input  winc, wData, rinc, flush, clr_err,
      output rData, rEmpty, rHalf_empty, wFull, wHalf_full, count,
             wOverflow, rUnderflow
   );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Single-clock parametrised FIFO with registered read data,
//               registered flags/fill count, programmable half thresholds,
//               sticky overflow/underflow and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
   parameter int DATA_WIDTH = 9,
   parameter int DEPTH      = 16,
   parameter int HF_THRESH  = DEPTH/2,
   parameter int HE_THRESH  = DEPTH/2
) (
   input  wire               wclk,
   input  wire               wrst,
   sync_fifo_param_if.slave  bus
);
   localparam int c_AW = $clog2(DEPTH);
   localparam int c_PW = c_AW + 1;
   localparam logic [c_PW-1:0] c_HF    = c_PW'(HF_THRESH);
   localparam logic [c_PW-1:0] c_HE    = c_PW'(HE_THRESH);
   localparam logic [c_PW-1:0] c_DEPTH = c_PW'(DEPTH);

   // Reject illegal geometry at elaboration time.
   generate
      if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("sync_fifo_param: DEPTH must be a power of 2 and >= 4");
      end
      if (HF_THRESH > DEPTH || HE_THRESH > DEPTH ||
          HF_THRESH < 0 || HE_THRESH < 0) begin : g_bad_thresh
         $error("sync_fifo_param: thresholds must lie within 0..DEPTH");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [c_PW-1:0]       r_wptr;
   logic [c_PW-1:0]       r_rptr;
   logic [c_PW-1:0]       r_count;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_empty;
   logic                  r_half_empty;
   logic                  r_full;
   logic                  r_half_full;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_wr_err;
   logic                  w_rd_err;
   logic [c_PW-1:0]       w_count_nxt;

   // Acceptance uses the registered (pre-edge) flags; flush blocks both ports.
   always_comb begin
      w_wr_acc    = bus.winc & ~r_full  & ~bus.flush;
      w_rd_acc    = bus.rinc & ~r_empty & ~bus.flush;
      w_wr_err    = bus.winc & r_full;
      w_rd_err    = bus.rinc & r_empty;
      w_count_nxt = r_count;
      if (bus.flush) begin
         w_count_nxt = '0;
      end else begin
         w_count_nxt = r_count + c_PW'(w_wr_acc) - c_PW'(w_rd_acc);
      end
   end

   // Storage array: written only on an accepted write, never reset.
   always_ff @(posedge wclk) begin
      if (w_wr_acc) begin
         r_mem[r_wptr[c_AW-1:0]] <= bus.wData;
      end
   end

   // Pointers, count, read data, flags and sticky errors.
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_rdata      <= '0;
         r_empty      <= 1'b1;
         r_half_empty <= 1'b1;
         r_full       <= 1'b0;
         r_half_full  <= (HF_THRESH == 0);
         r_overflow   <= 1'b0;
         r_underflow  <= 1'b0;
      end else begin
         if (bus.flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_wr_acc) begin
               r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
               r_rptr  <= r_rptr + 1'b1;
               r_rdata <= r_mem[r_rptr[c_AW-1:0]];
            end
         end
         r_count      <= w_count_nxt;
         r_empty      <= (w_count_nxt == '0);
         r_half_empty <= (w_count_nxt <= c_HE);
         r_full       <= (w_count_nxt == c_DEPTH);
         r_half_full  <= (w_count_nxt >= c_HF);
         // A fresh error in the clearing cycle wins over clr_err.
         r_overflow   <= (r_overflow  & ~bus.clr_err) | w_wr_err;
         r_underflow  <= (r_underflow & ~bus.clr_err) | w_rd_err;
      end
   end

   assign bus.rData       = r_rdata;
   assign bus.rEmpty      = r_empty;
   assign bus.rHalf_empty = r_half_empty;
   assign bus.wFull       = r_full;
   assign bus.wHalf_full  = r_half_full;
   assign bus.count       = r_count;
   assign bus.wOverflow   = r_overflow;
   assign bus.rUnderflow  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Directed self-checking bench for sync_fifo_param (9x16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;
   localparam int c_DW = 9;
   localparam int c_DEPTH = 16;

   logic wclk;
   logic wrst;
   int   n_checks;
   int   n_errors;

   sync_fifo_param_if #(.DATA_WIDTH(c_DW), .DEPTH(c_DEPTH)) bus ();

   sync_fifo_param #(
      .DATA_WIDTH (c_DW),
      .DEPTH      (c_DEPTH),
      .HF_THRESH  (c_DEPTH/2),
      .HE_THRESH  (c_DEPTH/2)
   ) u_dut (
      .wclk (wclk),
      .wrst (wrst),
      .bus  (bus)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle; inputs set afterwards apply at the next edge.
   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   task automatic idle();
      bus.winc = 1'b0; bus.rinc = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_count"},  32'(bus.count), 32'd0);
      chk({tag, "_empty"},  32'(bus.rEmpty), 32'd1);
      chk({tag, "_hempty"}, 32'(bus.rHalf_empty), 32'd1);
      chk({tag, "_full"},   32'(bus.wFull), 32'd0);
      chk({tag, "_hfull"},  32'(bus.wHalf_full), 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      wrst = 1'b1;
      bus.wData = '0;
      idle();
      repeat (3) tick();
      // Reset state
      chk_reset_state("rst");
      chk("rst_rdata", 32'(bus.rData), 32'h0);
      chk("rst_ovf",   32'(bus.wOverflow), 32'd0);
      chk("rst_udf",   32'(bus.rUnderflow), 32'd0);
      wrst = 1'b0;
      tick();

      // Fill 0x100..0x10F
      for (int i = 0; i < 16; i++) begin
         bus.winc = 1'b1; bus.wData = 9'(32'h100 + i);
         tick();
         chk("fill_count", 32'(bus.count), 32'(i + 1));
         chk("fill_hfull", 32'(bus.wHalf_full), 32'((i + 1) >= 8));
         chk("fill_full",  32'(bus.wFull), 32'(i == 15));
         chk("fill_empty", 32'(bus.rEmpty), 32'd0);
      end
      bus.wData = 9'h1FF;
      tick();
      bus.winc = 1'b0;
      chk("ovf_flag",  32'(bus.wOverflow), 32'd1);
      chk("ovf_count", 32'(bus.count), 32'd16);
      chk("ovf_full",  32'(bus.wFull), 32'd1);

      // Drain in order
      for (int k = 0; k < 16; k++) begin
         bus.rinc = 1'b1;
         tick();
         chk("drain_data",   32'(bus.rData), 32'h100 + 32'(k));
         chk("drain_count",  32'(bus.count), 32'(15 - k));
         chk("drain_hempty", 32'(bus.rHalf_empty), 32'((15 - k) <= 8));
      end
      tick();
      bus.rinc = 1'b0;
      chk("udf_flag",  32'(bus.rUnderflow), 32'd1);
      chk("udf_hold",  32'(bus.rData), 32'h10F);
      chk("udf_empty", 32'(bus.rEmpty), 32'd1);
      chk("udf_ovf",   32'(bus.wOverflow), 32'd1);
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      chk("clr_ovf", 32'(bus.wOverflow), 32'd0);
      chk("clr_udf", 32'(bus.rUnderflow), 32'd0);

      // Wrap: 40 write/read pairs across several pointer wraps
      for (int i = 0; i < 40; i++) begin
         bus.winc = 1'b1; bus.wData = 9'(32'h20 + i);
         tick();
         bus.winc = 1'b0;
         chk("wrap_nempty", 32'(bus.rEmpty), 32'd0);
         bus.rinc = 1'b1;
         tick();
         bus.rinc = 1'b0;
         chk("wrap_data", 32'(bus.rData), 32'h20 + 32'(i));
      end
      chk("wrap_count", 32'(bus.count), 32'd0);
      chk("wrap_udf",   32'(bus.rUnderflow), 32'd0);

      // Simultaneous read+write at count 8
      for (int i = 0; i < 8; i++) begin
         bus.winc = 1'b1; bus.wData = 9'(32'h50 + i);
         tick();
      end
      for (int j = 0; j < 20; j++) begin
         bus.winc = 1'b1; bus.rinc = 1'b1; bus.wData = 9'(32'h58 + j);
         tick();
         chk("sim_data",  32'(bus.rData), 32'h50 + 32'(j));
         chk("sim_count", 32'(bus.count), 32'd8);
      end
      bus.winc = 1'b0;
      for (int j = 0; j < 8; j++) begin
         bus.rinc = 1'b1;
         tick();
         chk("sim_tail", 32'(bus.rData), 32'h64 + 32'(j));
      end
      bus.rinc = 1'b0;
      chk("sim_empty", 32'(bus.rEmpty), 32'd1);

      // Flush at count 5 with a competing write
      for (int i = 0; i < 5; i++) begin
         bus.winc = 1'b1; bus.wData = 9'(32'hA0 + i);
         tick();
      end
      chk("pre_flush_count", 32'(bus.count), 32'd5);
      bus.flush = 1'b1; bus.winc = 1'b1; bus.wData = 9'h1AA;
      tick();
      idle();
      chk_reset_state("flush");
      chk("flush_rdata", 32'(bus.rData), 32'h6B);
      chk("flush_ovf",   32'(bus.wOverflow), 32'd0);

      // Write+read while empty: write taken, read rejected, underflow set
      bus.winc = 1'b1; bus.rinc = 1'b1; bus.wData = 9'h033;
      tick();
      idle();
      chk("we_count", 32'(bus.count), 32'd1);
      chk("we_udf",   32'(bus.rUnderflow), 32'd1);
      chk("we_hold",  32'(bus.rData), 32'h6B);
      bus.rinc = 1'b1;
      tick();
      bus.rinc = 1'b0;
      chk("we_data", 32'(bus.rData), 32'h033);

      // clr_err with a new underflow in the same cycle keeps the flag set
      bus.clr_err = 1'b1; bus.rinc = 1'b1;
      tick();
      idle();
      chk("clr_race_udf", 32'(bus.rUnderflow), 32'd1);

      // Asynchronous reset mid-cycle at count 10
      for (int i = 0; i < 10; i++) begin
         bus.winc = 1'b1; bus.wData = 9'(32'hC0 + i);
         tick();
      end
      bus.winc = 1'b0;
      chk("pre_rst_count", 32'(bus.count), 32'd10);
      chk("pre_rst_hfull", 32'(bus.wHalf_full), 32'd1);
      #2;
      wrst = 1'b1;
      #1;
      chk_reset_state("arst");
      chk("arst_rdata", 32'(bus.rData), 32'h0);
      chk("arst_udf",   32'(bus.rUnderflow), 32'd0);
      #1;
      wrst = 1'b0;
      tick();
      chk("post_rst_count", 32'(bus.count), 32'd0);
      chk("post_rst_empty", 32'(bus.rEmpty), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
